// File: rtl/counter_control.sv
// Button conditioning and count pacing ahead of the seven-segment counter:
// synchronize, debounce and edge-detect two buttons, toggle run/direction, prescale to the count rate.

module counter_control_btn #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);
   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         press   <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= btn;
         sync2   <= sync1;
         level_d <= level;
         press   <= level & ~level_d;
         // Only an unbroken run of differing samples moves the debounced level.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// state   | meaning
// STOPPED | prescaler held at 0, no enable pulses
// RUNNING | prescaler counting, enable pulse after each terminal count
module counter_control #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int TICK_CYCLES     = 100_000_000
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic btn_run,
   input  logic btn_dir,
   output logic enable,
   output logic forward,
   output logic running
);
   typedef enum logic {
      STOPPED = 1'b0,
      RUNNING = 1'b1
   } run_state_t;

   localparam int               PRE_W   = $clog2(TICK_CYCLES);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_CYCLES - 1);

   logic             press_run;
   logic             press_dir;
   run_state_t       state;
   run_state_t       state_next;
   logic [PRE_W-1:0] presc;
   logic [PRE_W-1:0] presc_next;
   logic             enable_next;
   logic             forward_next;

   counter_control_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_run (
      .clk   (clk_100MHz),
      .rst_n (reset),
      .btn   (btn_run),
      .press (press_run)
   );

   counter_control_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dir (
      .clk   (clk_100MHz),
      .rst_n (reset),
      .btn   (btn_dir),
      .press (press_dir)
   );

   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         state   <= STOPPED;
         presc   <= '0;
         enable  <= 1'b0;
         forward <= 1'b1;
      end else begin
         state   <= state_next;
         presc   <= presc_next;
         enable  <= enable_next;
         forward <= forward_next;
      end
   end

   // A run press always clears the prescaler and wins over a coincident terminal count.
   always_comb begin
      state_next   = state;
      presc_next   = '0;
      enable_next  = 1'b0;
      forward_next = forward ^ press_dir;
      case (state)
         STOPPED: begin
            if (press_run) state_next = RUNNING;
         end
         RUNNING: begin
            if (press_run) begin
               state_next = STOPPED;
            end else begin
               enable_next = (presc == PRE_MAX);
               presc_next  = (presc == PRE_MAX) ? '0 : presc + 1'b1;
            end
         end
         default: state_next = STOPPED;
      endcase
   end

   assign running = (state == RUNNING);
endmodule

// File: tb/tb_counter_control.sv
// Scoreboard bench for counter_control with DEBOUNCE_CYCLES=4, TICK_CYCLES=5.
// Expected output events are keyed by rising-edge index; a negedge monitor pops and compares them.

module tb_counter_control;
   logic clk;
   logic reset;
   logic btn_run;
   logic btn_dir;
   logic enable;
   logic forward;
   logic running;

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   typedef struct {
      int at_edge;
      bit en;
      bit fwd;
      bit run;
   } ev_t;

   ev_t exp_q[$];

   counter_control #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(5)) dut (
      .clk_100MHz (clk),
      .reset      (reset),
      .btn_run    (btn_run),
      .btn_dir    (btn_dir),
      .enable     (enable),
      .forward    (forward),
      .running    (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Insert an expected event, kept sorted by edge index.
   task automatic sched(input int e, input bit en, input bit f, input bit r);
      ev_t x;
      int  i;
      x.at_edge = e;
      x.en      = en;
      x.fwd     = f;
      x.run     = r;
      i = 0;
      while (i < exp_q.size() && exp_q[i].at_edge <= e) i++;
      exp_q.insert(i, x);
   endtask

   task automatic push_ticks(input int base, input int k_lo, input int k_hi, input bit f);
      for (int k = k_lo; k <= k_hi; k++) sched(base + 5 * k, 1'b1, f, 1'b1);
   endtask

   task automatic wait_until(input int e);
      while (edge_n < e) @(negedge clk);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at edge %0d", name, act, exp, edge_n);
      end
   endtask

   bit p_fwd = 1'b1;
   bit p_run = 1'b0;

   always @(negedge clk) begin
      ev_t e;
      if (reset && (enable || forward != p_fwd || running != p_run)) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event edge=%0d en=%0b fwd=%0b run=%0b (none expected)",
                     edge_n, enable, forward, running);
         end else begin
            e = exp_q.pop_front();
            if (e.at_edge != edge_n || e.en != enable || e.fwd != forward || e.run != running) begin
               failures++;
               $display("FAIL event actual edge=%0d en=%0b fwd=%0b run=%0b expected edge=%0d en=%0b fwd=%0b run=%0b",
                        edge_n, enable, forward, running, e.at_edge, e.en, e.fwd, e.run);
            end
         end
      end
      p_fwd = forward;
      p_run = running;
   end

   int t;
   int e1;
   int t2;
   int s;
   int t3;
   int e3;
   int t4;
   int e4;

   initial begin
      reset   = 1'b0;
      btn_run = 1'b0;
      btn_dir = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_enable", enable, 0);
      check("rst_forward", forward, 1);
      check("rst_running", running, 0);
      check("rst_presc", int'(dut.presc), 0);
      reset = 1'b1;

      // Idle after reset release: no events for 50 cycles.
      t = edge_n;
      wait_until(t + 50);
      check("idle_enable", enable, 0);
      check("idle_forward", forward, 1);
      check("idle_running", running, 0);

      // Bounces of 3 cycles are rejected.
      repeat (10) begin
         btn_run = 1'b1;
         repeat (3) @(negedge clk);
         btn_run = 1'b0;
         repeat (3) @(negedge clk);
      end
      check("glitch_running", running, 0);
      repeat (4) @(negedge clk);

      // First run press: running 8 edges after hold, then ticks every 5.
      t  = edge_n;
      btn_run = 1'b1;
      e1 = t + 8;
      sched(e1, 1'b0, 1'b1, 1'b1);
      push_ticks(e1, 1, 12, 1'b1);
      wait_until(t + 10);
      btn_run = 1'b0;

      // Stop press, clear of any terminal count.
      t2 = e1 + 53;
      wait_until(t2);
      btn_run = 1'b1;
      s = t2 + 8;
      sched(s, 1'b0, 1'b1, 1'b0);
      wait_until(t2 + 10);
      btn_run = 1'b0;

      // Restart: first enable 5 edges after running rises; direction presses while running.
      t3 = s + 20;
      wait_until(t3);
      check("stopped_running", running, 0);
      btn_run = 1'b1;
      e3 = t3 + 8;
      sched(e3, 1'b0, 1'b1, 1'b1);
      push_ticks(e3, 1, 2, 1'b1);
      push_ticks(e3, 3, 5, 1'b0);
      push_ticks(e3, 6, 8, 1'b1);
      push_ticks(e3, 9, 11, 1'b0);
      wait_until(t3 + 10);
      btn_run = 1'b0;

      wait_until(e3 + 4);
      btn_dir = 1'b1;
      sched(e3 + 12, 1'b0, 1'b0, 1'b1);
      wait_until(e3 + 12);
      btn_dir = 1'b0;

      wait_until(e3 + 19);
      btn_dir = 1'b1;
      sched(e3 + 27, 1'b0, 1'b1, 1'b1);
      wait_until(e3 + 27);
      btn_dir = 1'b0;

      // Press pulse lands in the enable cycle at e3+40: forward flips one edge later.
      wait_until(e3 + 33);
      btn_dir = 1'b1;
      sched(e3 + 41, 1'b0, 1'b0, 1'b1);
      wait_until(e3 + 41);
      btn_dir = 1'b0;

      // Stop press pulse coincides with prescaler terminal count before edge e3+60.
      wait_until(e3 + 52);
      btn_run = 1'b1;
      sched(e3 + 60, 1'b0, 1'b0, 1'b0);
      wait_until(e3 + 60);
      btn_run = 1'b0;
      check("collide_presc", int'(dut.presc), 0);
      check("collide_enable", enable, 0);
      check("collide_running", running, 0);

      // Run again and hit reset asynchronously while enable is high.
      t4 = e3 + 80;
      wait_until(t4);
      btn_run = 1'b1;
      e4 = t4 + 8;
      sched(e4, 1'b0, 1'b0, 1'b1);
      push_ticks(e4, 1, 2, 1'b0);
      wait_until(t4 + 8);
      btn_run = 1'b0;
      wait_until(e4 + 10);
      #1;
      check("pre_reset_enable", enable, 1);
      reset = 1'b0;
      #1;
      check("async_rst_enable", enable, 0);
      check("async_rst_forward", forward, 1);
      check("async_rst_running", running, 0);
      check("async_rst_presc", int'(dut.presc), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      t = edge_n;
      wait_until(t + 50);
      check("post_rst_enable", enable, 0);
      check("post_rst_forward", forward, 1);
      check("post_rst_running", running, 0);
      check("pending_events", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
